// File: rtl/hex_record_parser.sv
// Streaming Intel HEX record parser: one ASCII character in, data bytes with absolute addresses out.
// Optional macro EXT_ADDR_EN enables type-04 extended linear address records (upper address bits).
module hex_record_parser #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [7:0]        CHAR,
    input  logic              CHAR_VLD,
    output logic              CHAR_RDY,
    output logic [7:0]        BYTE_OUT,
    output logic [ADDR_W-1:0] ADDR_OUT,
    output logic              BYTE_VLD,
    input  logic              BYTE_RDY,
    output logic              REC_DONE,
    output logic              CHK_ERR,
    output logic              FMT_ERR,
    output logic              EOF
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        ADDR  = 3'd2,
        TYPE  = 3'd3,
        DATA  = 3'd4,
        CSUM  = 3'd5
    } state_t;

    localparam logic [7:0] COLON = 8'h3A;

    function automatic logic is_hex(input logic [7:0] c);
        is_hex = ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Only meaningful for '0'-'9' and 'A'-'F'; letters have bit 6 set.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        hex_val = c[6] ? (c[3:0] + 4'd9) : c[3:0];
    endfunction

    state_t            state_r;
    logic              half_r;
    logic [3:0]        hi_nib_r;
    logic              addr_cnt_r;
    logic [7:0]        len_r;
    logic [15:0]       addr_r;
    logic [7:0]        type_r;
    logic [7:0]        idx_r;
    logic [7:0]        sum_r;

    logic              accept_s;
    logic              hex_s;
    logic [7:0]        byte_s;
    logic [7:0]        sum_next_s;
    logic [15:0]       low_addr_s;
    logic [15:0]       base_s;
    logic [ADDR_W-1:0] addr_next_s;

`ifdef EXT_ADDR_EN
    logic [15:0]       base_r;
    logic [15:0]       ext_r;
    assign base_s = base_r;
`else
    assign base_s = 16'h0000;
`endif

    assign CHAR_RDY = !BYTE_VLD || BYTE_RDY;
    assign accept_s = CHAR_VLD && CHAR_RDY;

    // Decode the incoming character and the byte/address it would complete
    always_comb begin
        hex_s       = is_hex(CHAR);
        byte_s      = {hi_nib_r, hex_val(CHAR)};
        sum_next_s  = sum_r + byte_s;
        low_addr_s  = addr_r + {8'd0, idx_r};
        addr_next_s = ADDR_W'({base_s, low_addr_s});
    end

    // Record FSM with field capture, running checksum and registered outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= IDLE;
            half_r     <= 1'b0;
            hi_nib_r   <= 4'h0;
            addr_cnt_r <= 1'b0;
            len_r      <= 8'h00;
            addr_r     <= 16'h0000;
            type_r     <= 8'h00;
            idx_r      <= 8'h00;
            sum_r      <= 8'h00;
            BYTE_OUT   <= 8'h00;
            ADDR_OUT   <= {ADDR_W{1'b0}};
            BYTE_VLD   <= 1'b0;
            REC_DONE   <= 1'b0;
            CHK_ERR    <= 1'b0;
            FMT_ERR    <= 1'b0;
            EOF        <= 1'b0;
`ifdef EXT_ADDR_EN
            base_r     <= 16'h0000;
            ext_r      <= 16'h0000;
`endif
        end else begin
            REC_DONE <= 1'b0;
            CHK_ERR  <= 1'b0;
            FMT_ERR  <= 1'b0;
            if (BYTE_VLD && BYTE_RDY) begin
                BYTE_VLD <= 1'b0;
            end
            if (accept_s) begin
                if (CHAR == COLON) begin
                    FMT_ERR <= (state_r != IDLE);
                    EOF     <= 1'b0;
                    state_r <= COUNT;
                    sum_r   <= 8'h00;
                    half_r  <= 1'b0;
                end else if (state_r == IDLE) begin
                    state_r <= IDLE;
                end else if (!hex_s) begin
                    FMT_ERR <= 1'b1;
                    state_r <= IDLE;
                    half_r  <= 1'b0;
                end else if (!half_r) begin
                    hi_nib_r <= hex_val(CHAR);
                    half_r   <= 1'b1;
                end else begin
                    half_r <= 1'b0;
                    sum_r  <= sum_next_s;
                    case (state_r)
                        COUNT: begin
                            len_r      <= byte_s;
                            addr_cnt_r <= 1'b0;
                            state_r    <= ADDR;
                        end
                        ADDR: begin
                            if (!addr_cnt_r) begin
                                addr_r[15:8] <= byte_s;
                                addr_cnt_r   <= 1'b1;
                            end else begin
                                addr_r[7:0]  <= byte_s;
                                state_r      <= TYPE;
                            end
                        end
                        TYPE: begin
                            type_r  <= byte_s;
                            idx_r   <= 8'h00;
                            state_r <= (len_r != 8'h00) ? DATA : CSUM;
                        end
                        DATA: begin
                            // Bytes go out before the checksum is known; CHK_ERR tells downstream to discard.
                            if (type_r == 8'h00) begin
                                BYTE_OUT <= byte_s;
                                ADDR_OUT <= addr_next_s;
                                BYTE_VLD <= 1'b1;
                            end
`ifdef EXT_ADDR_EN
                            if (idx_r == 8'h00) begin
                                ext_r[15:8] <= byte_s;
                            end else if (idx_r == 8'h01) begin
                                ext_r[7:0]  <= byte_s;
                            end else begin
                                ext_r       <= ext_r;
                            end
`endif
                            idx_r <= idx_r + 8'h01;
                            if (idx_r == (len_r - 8'h01)) begin
                                state_r <= CSUM;
                            end
                        end
                        CSUM: begin
                            state_r <= IDLE;
                            if (sum_next_s == 8'h00) begin
                                REC_DONE <= 1'b1;
                                if (type_r == 8'h01) begin
                                    EOF <= 1'b1;
                                end
`ifdef EXT_ADDR_EN
                                if ((type_r == 8'h04) && (len_r == 8'h02)) begin
                                    base_r <= ext_r;
                                end
`endif
                            end else begin
                                CHK_ERR <= 1'b1;
                            end
                        end
                        default: begin
                            state_r <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
